// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 key schedule engine.
package aes_pkg;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {IDLE, PRESENT, SUB, EXPAND} key_expand_state_t;

  localparam int unsigned NR = 10;

  // Entry 0 is unused: the table is indexed by the round being produced.
  localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Inverse as x^254 (square-and-multiply), then the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// Synchronous AES S-box: the substituted byte appears one clock after the input.
module aes_sbox
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  logic [7:0] r_byte;

  always_ff @(posedge clk) begin
    r_byte <= sbox(i_byte);
  end

  assign o_byte = r_byte;
endmodule

// File: rtl/rot_word.sv
// Byte rotation of a key-schedule word: [a0 a1 a2 a3] -> [a1 a2 a3 a0] when enabled.
module rot_word (
  input  logic        i_enable,
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  assign o_word = i_enable ? {i_word[23:0], i_word[31:24]} : i_word;
endmodule

// File: rtl/sub_word.sv
// SubWord: four synchronous S-boxes, one per byte, with one cycle of latency.
module sub_word (
  input  logic        clk,
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .clk    (clk),
        .i_byte (i_word[8*gi +: 8]),
        .o_byte (o_word[8*gi +: 8])
      );
    end
  endgenerate
endmodule

// File: rtl/key_expand.sv
// Sequential AES-128 key schedule: presents round keys 0..10 over a valid/ready handshake.
// Define KEY_EXPAND_CACHE_EN to add an 11-entry round-key cache and the replay input.
module key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         rk_ready,
`ifdef KEY_EXPAND_CACHE_EN
  input  logic         replay,
`endif
  output logic         rk_valid,
  output logic [127:0] rk,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done
);
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  key_expand_state_t r_state;
  key_expand_state_t w_state_next;
  block_t            r_rk;
  block_t            w_rk_next;
  block_t            w_cache_rd;
  logic [3:0]        r_round;
  logic [3:0]        w_round_inc;
  logic              r_done;
  logic              w_accept;
  logic              w_last;
  logic              w_replay_go;
  logic              w_replay_mode;
  word_t             w_rot;
  word_t             w_sub;
  word_t             w_t;
  word_t             w_w0_next;
  word_t             w_w1_next;
  word_t             w_w2_next;
  word_t             w_w3_next;

  assign w_accept    = (r_state == PRESENT) && rk_ready;
  assign w_last      = (r_round == LAST_ROUND);
  assign w_round_inc = r_round + 4'd1;

  rot_word u_rot (
    .i_enable (1'b1),
    .i_word   (r_rk[31:0]),
    .o_word   (w_rot)
  );

  sub_word u_sub (
    .clk    (clk),
    .i_word (w_rot),
    .o_word (w_sub)
  );

  // Each new word folds in the one just produced, so the chain runs w0' -> w3'.
  assign w_t       = w_sub ^ {RCON[w_round_inc], 24'h0};
  assign w_w0_next = r_rk[127:96] ^ w_t;
  assign w_w1_next = r_rk[95:64]  ^ w_w0_next;
  assign w_w2_next = r_rk[63:32]  ^ w_w1_next;
  assign w_w3_next = r_rk[31:0]   ^ w_w2_next;
  assign w_rk_next = {w_w0_next, w_w1_next, w_w2_next, w_w3_next};

`ifdef KEY_EXPAND_CACHE_EN
  block_t     r_cache [0:NR];
  logic       r_cache_valid;
  logic       r_replay_mode;
  logic [3:0] w_cache_addr;

  assign w_replay_go   = replay && !start && (r_state == IDLE) && r_cache_valid;
  assign w_replay_mode = r_replay_mode;
  assign w_cache_addr  = ((r_state == PRESENT) && !w_last) ? w_round_inc : 4'd0;
  assign w_cache_rd    = r_cache[w_cache_addr];

  always_ff @(posedge clk) begin
    if (r_state == PRESENT) r_cache[r_round] <= r_rk;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cache_valid <= 1'b0;
      r_replay_mode <= 1'b0;
    end else if (start) begin
      r_cache_valid <= 1'b0;
      r_replay_mode <= 1'b0;
    end else if (w_replay_go) begin
      r_replay_mode <= 1'b1;
    end else if (w_accept && w_last) begin
      r_cache_valid <= 1'b1;
      r_replay_mode <= 1'b0;
    end
  end
`else
  assign w_replay_go   = 1'b0;
  assign w_replay_mode = 1'b0;
  assign w_cache_rd    = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = PRESENT;
    end else begin
      case (r_state)
        IDLE:    if (w_replay_go) w_state_next = PRESENT;
        PRESENT: if (rk_ready) w_state_next = w_last ? IDLE : (w_replay_mode ? PRESENT : SUB);
        SUB:     w_state_next = EXPAND;
        EXPAND:  w_state_next = PRESENT;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    rk_valid = (r_state == PRESENT);
    busy     = (r_state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rk    <= '0;
      r_round <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rk    <= key;
        r_round <= '0;
      end else if (w_replay_go) begin
        r_rk    <= w_cache_rd;
        r_round <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          r_done <= 1'b1;
        end else if (w_replay_mode) begin
          r_rk    <= w_cache_rd;
          r_round <= w_round_inc;
        end
      end else if (r_state == EXPAND) begin
        r_rk    <= w_rk_next;
        r_round <= w_round_inc;
      end
    end
  end

  assign rk    = r_rk;
  assign round = r_round;
  assign done  = r_done;
endmodule

// File: tb/tb_key_expand.sv
// Scoreboard bench for key_expand: a FIPS-197 style key-expansion model feeds an
// expected-key queue, and a negedge monitor checks every accepted round key.
module tb_key_expand;
  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] key;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk;
  logic [3:0]   round;
  logic         busy;
  logic         done;
`ifdef KEY_EXPAND_CACHE_EN
  logic         replay;
`endif

  key_expand dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key      (key),
    .rk_ready (rk_ready),
`ifdef KEY_EXPAND_CACHE_EN
    .replay   (replay),
`endif
    .rk_valid (rk_valid),
    .rk       (rk),
    .round    (round),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [127:0] rk;
    int           rnd;
  } exp_t;

  exp_t         exp_q[$];
  logic [7:0]   sbox_ref [256];
  logic [127:0] ref_keys [0:10];
  int           checks = 0;
  int           errors = 0;
  int           cycle = 0;
  int           done_cycle = -1;
  int           exp_gap = 3;
  int           gap = -1;
  bit           exp_done_next = 0;
  bit           expect_r0 = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) prod ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--) if (prod[i]) prod ^= 16'h011b << (i - 8);
    return prod[7:0];
  endfunction

  task automatic build_sbox_ref();
    logic [7:0] inv;
    logic [7:0] b;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul_ref(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sbox_ref[x] = b;
    end
  endtask

  // Classic 44-word KeyExpansion; Rcon generated by repeated doubling in GF(2^8).
  task automatic expand_ref(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i - 1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_ref[temp[31:24]], sbox_ref[temp[23:16]], sbox_ref[temp[15:8]], sbox_ref[temp[7:0]]};
        temp[31:24] ^= rc;
        rc = gf_mul_ref(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ temp;
    end
    for (int r = 0; r <= 10; r++) ref_keys[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic push_all();
    exp_t e;
    exp_q.delete();
    for (int r = 0; r <= 10; r++) begin
      e.rk  = ref_keys[r];
      e.rnd = r;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [127:0] k);
    key   = k;
    start = 1'b1;
    expand_ref(k);
    push_all();
    exp_gap = 3;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input bit rnd_ready);
    int n;
    for (n = 0; n < limit; n++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy) break;
      if (rnd_ready) rk_ready = ($urandom_range(0, 3) != 0);
    end
    if (n == limit) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: timeout with %0d keys outstanding", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_accept(input int r);
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rk_valid && rk_ready && !start && int'(round) == r) break;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL wait_accept: round %0d never accepted", r);
    end
  endtask

  task automatic wait_present(input int r);
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rk_valid && int'(round) == r) break;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL wait_present: round %0d never presented", r);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rk_valid"}, 128'(rk_valid), 0);
    chk({tag, "_busy"}, 128'(busy), 0);
    chk({tag, "_done"}, 128'(done), 0);
    chk({tag, "_rk"}, rk, 0);
    chk({tag, "_round"}, 128'(round), 0);
  endtask

  // Monitor: pops one expectation per accepted key, tracks latency and the done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_done_next = 0;
        gap           = -1;
        expect_r0     = 0;
      end else begin
        chk("done", 128'(done), 128'(exp_done_next));
        exp_done_next = 0;
        if (done) begin
          done_cycle = cycle;
          chk("done_with_valid", 128'(rk_valid), 0);
        end
        if (expect_r0) begin
          chk("start_latency_valid", 128'(rk_valid), 1);
          chk("start_round", 128'(round), 0);
          expect_r0 = 0;
        end
        if (gap >= 0) begin
          gap++;
          if (rk_valid || gap > exp_gap) begin
            chk("next_key_latency", 128'(gap), 128'(exp_gap));
            gap = -1;
          end
        end
        if (rk_valid && rk_ready && !start) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key: got round %0d rk %h with no key expected", round, rk);
          end else begin
            e = exp_q.pop_front();
            chk("rk", rk, e.rk);
            chk("round", 128'(round), 128'(e.rnd));
            $display("key round %0d rk %h", round, rk);
            if (e.rnd == 10) exp_done_next = 1;
            else gap = 0;
          end
        end
        if (start) begin
          gap       = -1;
          expect_r0 = 1;
        end
      end
    end
  end

  initial begin
    int start_cyc;
    reset    = 1'b1;
    start    = 1'b0;
    rk_ready = 1'b0;
    key      = '0;
`ifdef KEY_EXPAND_CACHE_EN
    replay   = 1'b0;
`endif
    build_sbox_ref();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    expand_ref(FIPS_KEY);
    chk("model_round1", ref_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_round10", ref_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    expand_ref(128'h0);
    chk("model_zero_round1", ref_keys[1], 128'h62636363626363636263636362636363);

    // Full FIPS run, ready always high: done 32 cycles after start.
    @(posedge clk); #1;
    rk_ready   = 1'b1;
    done_cycle = -1;
    start_cyc  = cycle;
    do_start(FIPS_KEY);
    wait_idle(100, 0);
    chk("done_cycle", 128'(done_cycle - start_cyc), 32);

    // Stall five cycles at round 4.
    do_start(FIPS_KEY);
    wait_accept(3);
    @(posedge clk); #1;
    rk_ready = 1'b0;
    wait_present(4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rk", rk, ref_keys[4]);
      chk("stall_round", 128'(round), 4);
      chk("stall_valid", 128'(rk_valid), 1);
    end
    @(posedge clk); #1;
    rk_ready = 1'b1;
    wait_idle(100, 0);

    // Restart with the all-zero key during EXPAND of round 6.
    do_start(FIPS_KEY);
    wait_accept(5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("expand_busy", 128'(busy), 1);
    chk("expand_valid", 128'(rk_valid), 0);
    do_start(128'h0);
    wait_idle(100, 0);

    // Asynchronous reset during SUB of round 3, then a clean FIPS run.
    do_start(FIPS_KEY);
    wait_accept(2);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    do_start(FIPS_KEY);
    wait_idle(100, 0);

    // start coinciding with the round-10 handshake: restart, no done.
    do_start({$urandom, $urandom, $urandom, $urandom});
    wait_accept(9);
    @(posedge clk); #1;
    rk_ready = 1'b0;
    wait_present(10);
    @(posedge clk); #1;
    rk_ready = 1'b1;
    do_start({$urandom, $urandom, $urandom, $urandom});
    wait_idle(100, 0);

    // Random keys with random back-pressure and one random mid-run restart.
    for (int run = 0; run < 6; run++) begin
      do_start({$urandom, $urandom, $urandom, $urandom});
      if (run == 2) begin
        repeat ($urandom_range(5, 40)) begin
          @(posedge clk); #1;
          rk_ready = ($urandom_range(0, 3) != 0);
        end
        do_start({$urandom, $urandom, $urandom, $urandom});
      end
      wait_idle(400, 1);
    end

`ifdef KEY_EXPAND_CACHE_EN
    // Replay the last completed schedule from the cache.
    replay  = 1'b1;
    push_all();
    exp_gap = 1;
    @(posedge clk); #1;
    replay  = 1'b0;
    chk("replay_valid", 128'(rk_valid), 1);
    chk("replay_round", 128'(round), 0);
    wait_idle(200, 1);
    exp_gap = 3;

    // Reset invalidates the cache, so replay is ignored.
    reset = 1'b1;
    @(posedge clk); #1;
    reset  = 1'b0;
    replay = 1'b1;
    @(posedge clk); #1;
    replay = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("replay_after_reset_busy", 128'(busy), 0);
      chk("replay_after_reset_valid", 128'(rk_valid), 0);
      @(posedge clk); #1;
    end
`endif

    chk("scoreboard_empty", 128'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
